// File: rtl/ts_scan_pkg.sv
// Shared types for the time-surface raster scanner: FSM states, per-pixel tag and cell-count helper.
package ts_scan_pkg;

   localparam int unsigned TS_GRID_SIZE   = 32;
   localparam int unsigned TS_COORD_BITS  = $clog2(TS_GRID_SIZE);

   typedef enum logic [1:0] {
      IDLE,
      SCAN,
      DRAIN,
      DONE
   } scan_state_t;

   typedef struct packed {
      logic [TS_COORD_BITS-1:0] x;
      logic [TS_COORD_BITS-1:0] y;
      logic                     sof;
      logic                     eof;
   } pix_tag_t;

   function automatic int unsigned num_cells(input int unsigned grid);
      return grid * grid;
   endfunction

endpackage

// File: rtl/ts_scan_fifo.sv
// Synchronous FIFO with occupancy count; push and pop may coincide even when full or empty.
module ts_scan_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic [CNT_W-1:0] o_count
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PW-1:0]    r_wr;
   logic [PW-1:0]    r_rd;
   logic [CNT_W-1:0] r_count;
   logic             w_do_pop;
   logic             w_do_push;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   assign w_do_pop  = i_pop && (r_count != '0);
   assign w_do_push = i_push && ((r_count != CNT_W'(DEPTH)) || w_do_pop);

   always_ff @(posedge i_clk) begin
      if (w_do_push) begin
         r_mem[r_wr] <= i_data;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (w_do_push) begin
            r_wr <= ptr_inc(r_wr);
         end
         if (w_do_pop) begin
            r_rd <= ptr_inc(r_rd);
         end
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   assign o_data  = r_mem[r_rd];
   assign o_empty = (r_count == '0);
   assign o_count = r_count;

endmodule

// File: rtl/time_surface_scanner.sv
// Raster-scan reader of the time-surface store, streaming decayed cells as tagged valid/ready beats.
// Optional frame-energy accumulator enabled by defining TS_SCAN_ENERGY_EN.
module time_surface_scanner
   import ts_scan_pkg::*;
#(
   parameter int unsigned GRID_SIZE   = 32,
   parameter int unsigned ADDR_BITS   = 10,
   parameter int unsigned VALUE_BITS  = 8,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned ENERGY_BITS = 18
) (
   input  logic                         i_clk,
   input  logic                         i_rst,
   input  logic                         i_start,
   output logic                         o_busy,
   output logic                         o_done,
   output logic [ADDR_BITS-1:0]         o_rd_addr,
   output logic                         o_rd_en,
   input  logic [VALUE_BITS-1:0]        i_rd_value,
   output logic                         o_out_valid,
   input  logic                         i_out_ready,
   output logic [VALUE_BITS-1:0]        o_out_value,
   output logic [$clog2(GRID_SIZE)-1:0] o_out_x,
   output logic [$clog2(GRID_SIZE)-1:0] o_out_y,
   output logic                         o_out_sof,
   output logic                         o_out_eof,
   output logic [ENERGY_BITS-1:0]       o_frame_energy
);

   localparam int unsigned NUM_CELLS = num_cells(GRID_SIZE);
   localparam int unsigned XB        = $clog2(GRID_SIZE);
   localparam int unsigned FW        = VALUE_BITS + $bits(pix_tag_t);
   localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OW        = CW + 2;
   localparam logic [ADDR_BITS-1:0] LAST_ADDR = ADDR_BITS'(NUM_CELLS - 1);

   if (FIFO_DEPTH < 3) begin : g_chk_depth
      $error("FIFO_DEPTH must be at least 3");
   end
   if (ENERGY_BITS < VALUE_BITS + ADDR_BITS) begin : g_chk_energy
      $error("ENERGY_BITS too narrow for a full frame sum");
   end
   if (GRID_SIZE != TS_GRID_SIZE) begin : g_chk_grid
      $error("GRID_SIZE must match ts_scan_pkg::TS_GRID_SIZE");
   end

   scan_state_t           r_state;
   logic [ADDR_BITS-1:0]  r_next_addr;
   logic [ADDR_BITS-1:0]  r_rd_addr;
   logic                  r_s0;
   logic                  r_rd_en;
   logic                  r_s2;
   pix_tag_t              r_s0_tag;
   pix_tag_t              r_s1_tag;
   pix_tag_t              r_s2_tag;
   logic                  r_done;

   pix_tag_t              w_tag;
   pix_tag_t              w_head_tag;
   logic [VALUE_BITS-1:0] w_head_value;
   logic [FW-1:0]         w_fifo_dout;
   logic [CW-1:0]         w_count;
   logic [OW-1:0]         w_occ;
   logic                  w_empty;
   logic                  w_valid;
   logic                  w_pop;
   logic                  w_credit;
   logic                  w_issue;
   logic                  w_drained;

   assign w_tag.x   = r_next_addr[XB-1:0];
   assign w_tag.y   = r_next_addr[ADDR_BITS-1:XB];
   assign w_tag.sof = (r_next_addr == '0);
   assign w_tag.eof = (r_next_addr == LAST_ADDR);

   // Next cycle's FIFO fill plus reads that will land before it; a slot is free only if this is below depth.
   assign w_occ    = OW'(w_count) + OW'(r_s2) + OW'(r_s0) + OW'(r_rd_en) - OW'(w_pop);
   assign w_credit = (w_occ < OW'(FIFO_DEPTH));
   assign w_issue  = ((r_state == IDLE) && i_start) || ((r_state == SCAN) && w_credit);
   assign w_drained = !r_s0 && !r_rd_en && !r_s2 && w_empty;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state     <= IDLE;
         r_next_addr <= '0;
         r_rd_addr   <= '0;
         r_s0        <= 1'b0;
         r_rd_en     <= 1'b0;
         r_s2        <= 1'b0;
         r_s0_tag    <= '0;
         r_s1_tag    <= '0;
         r_s2_tag    <= '0;
         r_done      <= 1'b0;
      end else begin
         r_s0     <= w_issue;
         r_rd_en  <= r_s0;
         r_s1_tag <= r_s0_tag;
         r_s2     <= r_rd_en;
         r_s2_tag <= r_s1_tag;
         r_done   <= 1'b0;
         if (w_issue) begin
            r_rd_addr   <= r_next_addr;
            r_s0_tag    <= w_tag;
            r_next_addr <= r_next_addr + 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (i_start) begin
                  r_state <= SCAN;
               end
            end
            SCAN: begin
               if (w_issue && (r_next_addr == LAST_ADDR)) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (w_drained) begin
                  r_state <= DONE;
                  r_done  <= 1'b1;
               end
            end
            DONE: begin
               r_state     <= IDLE;
               r_next_addr <= '0;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   ts_scan_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CW)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_push  (r_s2),
      .i_data  ({i_rd_value, r_s2_tag}),
      .i_pop   (w_pop),
      .o_data  (w_fifo_dout),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign {w_head_value, w_head_tag} = w_fifo_dout;
   assign w_valid = !w_empty;
   assign w_pop   = w_valid && i_out_ready;

   // Head data is gated so outputs read 0 whenever no beat is presented.
   assign o_out_valid = w_valid;
   assign o_out_value = w_valid ? w_head_value : '0;
   assign o_out_x     = w_valid ? w_head_tag.x : '0;
   assign o_out_y     = w_valid ? w_head_tag.y : '0;
   assign o_out_sof   = w_valid && w_head_tag.sof;
   assign o_out_eof   = w_valid && w_head_tag.eof;

   assign o_busy    = (r_state != IDLE);
   assign o_done    = r_done;
   assign o_rd_addr = r_rd_addr;
   assign o_rd_en   = r_rd_en;

`ifdef TS_SCAN_ENERGY_EN
   logic [ENERGY_BITS-1:0] r_acc;
   logic [ENERGY_BITS-1:0] r_energy;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc    <= '0;
         r_energy <= '0;
      end else begin
         if ((r_state == IDLE) && i_start) begin
            r_acc <= '0;
         end else if (w_pop) begin
            r_acc <= r_acc + ENERGY_BITS'(w_head_value);
         end
         if ((r_state == DRAIN) && w_drained) begin
            r_energy <= r_acc;
         end
      end
   end

   assign o_frame_energy = r_energy;
`else
   assign o_frame_energy = '0;
`endif

endmodule
